// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception/interrupt controller: register numbers,
// field positions, PRId, trap vector and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] PRID_VALUE  = 32'h2023_0007;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v = '0;
        v[SR_IM_LO +: 6] = im;
        v[SR_EXL]        = exl;
        v[SR_IE]         = ie;
        return v;
    endfunction

    function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD]           = bd;
        v[CAUSE_IP_LO +: 6]   = ip;
        v[CAUSE_EXC_LO +: 5]  = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 signal bundle. master = pipeline side, slave = CP0 side.
interface cp0_unit_if;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
        input  cp0_rdata, req, epc_out
    );

    modport slave (
        input  en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
        output cp0_rdata, req, epc_out
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; only instantiated when CP0_TIMER_EN is defined.
import cp0_pkg::*;

module cp0_timer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pending
);
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_pending <= 1'b0;
        end else begin
            r_count <= (i_wr && i_addr == REG_COUNT) ? i_wdata : r_count + 32'd1;
            // A Compare write acknowledges the pending tick even if the old value matched.
            if (i_wr && i_addr == REG_COMPARE) begin
                r_compare <= i_wdata;
                r_pending <= 1'b0;
            end else if (r_count == r_compare && r_compare != '0) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;
endmodule

// File: rtl/cp0_unit.sv
// CP0 exception/interrupt controller: SR/Cause/EPC/PRId, trap decision and flush request.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
import cp0_pkg::*;

module cp0_unit (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;

    logic [5:0]  w_eff_int;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr;
    logic [31:0] w_epc_trap;

    // Writes from a cancelled (trapping) instruction or alongside eret never land.
    assign w_wr = bus.en && !w_req && !bus.eret;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_pending;

    cp0_timer u_timer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr      (w_wr),
        .i_addr    (bus.cp0_addr),
        .i_wdata   (bus.cp0_wdata),
        .o_count   (w_count),
        .o_compare (w_compare),
        .o_pending (w_pending)
    );
    assign w_eff_int = bus.hw_int | {w_pending, 5'b0};
`else
    assign w_eff_int = bus.hw_int;
`endif

    assign w_int_req  = (|(w_eff_int & r_im)) && r_ie && !r_exl;
    assign w_exc_req  = (bus.exc_code_in != 5'd0) && !r_exl;
    assign w_req      = w_int_req || w_exc_req;
    assign w_epc_trap = (bus.bd_in ? bus.vpc - 32'd4 : bus.vpc) & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_ip  <= '0;
            r_exc <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= w_eff_int;
            if (w_req) begin
                r_exl <= 1'b1;
                r_exc <= w_int_req ? EXC_INT : bus.exc_code_in;
                r_bd  <= bus.bd_in;
                r_epc <= w_epc_trap;
            end else if (bus.eret) begin
                r_exl <= 1'b0;
            end else if (w_wr) begin
                case (bus.cp0_addr)
                    REG_SR: begin
                        r_im  <= bus.cp0_wdata[SR_IM_LO +: 6];
                        r_exl <= bus.cp0_wdata[SR_EXL];
                        r_ie  <= bus.cp0_wdata[SR_IE];
                    end
                    REG_EPC: r_epc <= bus.cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_addr)
            REG_SR:      bus.cp0_rdata = sr_word(r_im, r_exl, r_ie);
            REG_CAUSE:   bus.cp0_rdata = cause_word(r_bd, r_ip, r_exc);
            REG_EPC:     bus.cp0_rdata = r_epc;
            REG_PRID:    bus.cp0_rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
            REG_COUNT:   bus.cp0_rdata = w_count;
            REG_COMPARE: bus.cp0_rdata = w_compare;
`endif
            default:     bus.cp0_rdata = '0;
        endcase
    end

    assign bus.req     = w_req;
    assign bus.epc_out = (bus.en && bus.cp0_addr == REG_EPC) ? bus.cp0_wdata : r_epc;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: traps, masking, eret, cancelled writes, reset and reads.
module tb_cp0_unit;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        check_eq(tag, bus.cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.en = 1'b1;
        bus.cp0_addr = a;
        bus.cp0_wdata = d;
        tick();
        bus.en = 1'b0;
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    initial begin
        bus.en = 0; bus.cp0_addr = 0; bus.cp0_wdata = 0; bus.vpc = 0;
        bus.bd_in = 0; bus.exc_code_in = 0; bus.hw_int = 0; bus.eret = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and constant reads
        #1;
        check_eq("rst_req", {31'b0, bus.req}, 32'd0);
        check_eq("rst_epc_out", bus.epc_out, 32'd0);
        check_reg("rst_sr", 5'd12, 32'd0);
        check_reg("rst_cause", 5'd13, 32'd0);
        check_reg("rst_epc", 5'd14, 32'd0);
        check_reg("prid", 5'd15, 32'h2023_0007);
        check_reg("unmapped7", 5'd7, 32'd0);

        // Exception outside a delay slot
        bus.exc_code_in = 5'd12; bus.vpc = 32'h3010; bus.bd_in = 0;
        #1 check_eq("ov_req", {31'b0, bus.req}, 32'd1);
        tick();
        bus.exc_code_in = 0;
        check_reg("ov_cause", 5'd13, 32'h0000_0030);
        check_reg("ov_epc", 5'd14, 32'h3010);
        check_reg("ov_sr", 5'd12, 32'h0000_0002);
        check_eq("ov_epc_out", bus.epc_out, 32'h3010);

        // EXL masks further exceptions
        bus.exc_code_in = 5'd10;
        #1 check_eq("masked_req", {31'b0, bus.req}, 32'd0);
        bus.exc_code_in = 0;
        do_eret();
        check_reg("eret_sr", 5'd12, 32'd0);
        bus.exc_code_in = 5'd10; bus.vpc = 32'h3100;
        #1 check_eq("ri_req", {31'b0, bus.req}, 32'd1);
        tick();
        bus.exc_code_in = 0;
        check_reg("ri_cause", 5'd13, 32'h0000_0028);

        // mtc0 EPC together with eret: bypass visible, write dropped
        bus.en = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h4000; bus.eret = 1;
        #1 check_eq("bypass_epc_out", bus.epc_out, 32'h4000);
        tick();
        bus.en = 0; bus.eret = 0;
        check_reg("eret_drops_wr", 5'd14, 32'h3100);
        check_reg("eret_sr2", 5'd12, 32'd0);

        // Interrupt in a delay slot, with a simultaneous exception code
        mtc0(5'd12, 32'h0000_0401);
        check_reg("sr_write", 5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.vpc = 32'h3024; bus.bd_in = 1; bus.exc_code_in = 5'd4;
        #1 check_eq("int_req", {31'b0, bus.req}, 32'd1);
        tick();
        bus.hw_int = 0; bus.bd_in = 0; bus.exc_code_in = 0;
        check_reg("int_cause", 5'd13, 32'h8000_0400);
        check_reg("int_epc", 5'd14, 32'h3020);
        check_reg("int_sr", 5'd12, 32'h0000_0403);

        // mtc0 SR cancelled by a trap in the same cycle
        do_eret();
        bus.exc_code_in = 5'd5; bus.vpc = 32'h5000;
        bus.en = 1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC01;
        #1 check_eq("cancel_req", {31'b0, bus.req}, 32'd1);
        tick();
        bus.en = 0; bus.exc_code_in = 0;
        check_reg("cancel_sr", 5'd12, 32'h0000_0403);
        check_reg("cancel_cause", 5'd13, 32'h0000_0014);

        // EPC wraps modulo 2^32
        do_eret();
        bus.exc_code_in = 5'd4; bus.vpc = 32'h0; bus.bd_in = 1;
        tick();
        bus.exc_code_in = 0; bus.bd_in = 0;
        check_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        check_reg("wrap_cause", 5'd13, 32'h8000_0010);

        // Cause is read-only, EPC is writable
        do_eret();
        mtc0(5'd13, 32'hFFFF_FFFF);
        check_reg("cause_ro", 5'd13, 32'h8000_0010);
        mtc0(5'd14, 32'h1234_5678);
        check_reg("epc_wr", 5'd14, 32'h1234_5678);
`ifndef CP0_TIMER_EN
        mtc0(5'd9, 32'h55);
        check_reg("no_count", 5'd9, 32'd0);
`endif

        // Reset during a trapping cycle
        bus.exc_code_in = 5'd12; bus.vpc = 32'h7000; reset = 1;
        tick();
        reset = 0; bus.exc_code_in = 0;
        check_reg("rst_mid_sr", 5'd12, 32'd0);
        check_reg("rst_mid_cause", 5'd13, 32'd0);
        check_reg("rst_mid_epc", 5'd14, 32'd0);

`ifdef CP0_TIMER_EN
        begin
            bit seen;
            seen = 0;
            mtc0(5'd11, 32'd20);
            mtc0(5'd12, 32'h0000_8001);
            mtc0(5'd9, 32'd0);
            check_eq("tmr_idle_req", {31'b0, bus.req}, 32'd0);
            for (int i = 0; i < 60 && !seen; i++) begin
                if (bus.req) seen = 1;
                else tick();
            end
            check_eq("tmr_req_seen", {31'b0, seen}, 32'd1);
            tick();
            check_reg("tmr_cause", 5'd13, 32'h0000_8000);
            mtc0(5'd11, 32'd1000);
            tick();
            check_reg("tmr_pending_clr", 5'd13, 32'h0000_0000);
            mtc0(5'd9, 32'hFFFF_FFFF);
            check_reg("tmr_count_max", 5'd9, 32'hFFFF_FFFF);
            tick();
            check_reg("tmr_count_wrap", 5'd9, 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It consumes the exception code, PC and delay-slot flag that each pipeline register carries forward to the M stage. It decides whether the pipeline must trap and drives the `req` flush that loads every stage register with its trap PC and bubble contents. It also holds SR/Cause/EPC/PRId for `mfc0`/`mtc0`/`eret`.

## Interface
- No parameters. All constants live in the package.
- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: `mtc0` write strobe from the M stage.
- `cp0_addr` in 5: CP0 register number for reads and writes.
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data, combinational.
- `vpc` in 32: PC of the M-stage instruction. The pipeline keeps it valid on bubbles.
- `bd_in` in 1: M-stage instruction sits in a delay slot.
- `exc_code_in` in 5: accumulated exception code; 0 means none.
- `hw_int` in 6: external interrupt lines.
- `eret` in 1: `eret` in the M stage.
- `req` out 1: trap request. It flushes all stage registers and redirects fetch to 0x0000_4180.
- `epc_out` out 32: return target for `eret`.

## Operation
- **SR (reg 12)**
  - Fields: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - `mtc0` writes only these fields.
- **Cause (reg 13)**
  - Fields: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - Read-only to software; `mtc0` to 13 is ignored.
  - IP is loaded every cycle from the effective interrupt vector (`hw_int`, plus the timer bit when built in).
- **EPC (reg 14)**: fully writable by `mtc0`.
- **PRId (reg 15)**: constant 0x2023_0007; read-only.
- **Unmapped reads** return 0.
- **Trap decision**
  - `int_req` = |(eff_int & IM) & IE & !EXL.
  - `exc_req` = (exc_code_in != 0) & !EXL.
  - `req` = int_req | exc_req, combinational.
  - Interrupt takes priority over exception.
- **On a cycle with `req`=1, at the edge**
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= bd_in ? vpc-4 : vpc, with bits[1:0] forced to 00.
  - Any simultaneous `mtc0` is dropped, because that instruction is cancelled.
- **`eret`**: EXL <= 0 at the edge.
  - If `eret` and `en` are both asserted, `eret` wins and the write is dropped.
  - `req` cannot fire while EXL=1, so `eret`/`req` never collide.
- **`epc_out`**: EPC register value, bypassed to `cp0_wdata` when `en` && `cp0_addr`==14 in the same cycle.

## Timing
- Reset values at the first edge with `reset`=1: SR, Cause, EPC all 0.
- Outputs out of reset: `req`=0; `epc_out`=0; `cp0_rdata` is 0 except PRId.
- `req` has zero latency from `exc_code_in`/`hw_int`. State updates one edge later.
- `mtc0` is visible to `mfc0` from the next cycle.
- `cp0_rdata` reflects registered state, with no write bypass.
- Reset asserted during any cycle overrides trap, `mtc0` and `eret` updates.
- Once EXL=1, further exceptions and interrupts are masked until `eret` clears it.
- EPC arithmetic is 32-bit modulo: vpc 0x0000_0000 with BD gives 0xFFFF_FFFC.

## Configuration
- Macro: `CP0_TIMER_EN`.
- **Defined**
  - Count (reg 9) increments every cycle and wraps 0xFFFF_FFFF to 0.
  - `mtc0` to 9 loads Count; the increment resumes the next cycle.
  - Compare is reg 11.
  - `timer_pending` sets when Count==Compare and Compare!=0. It clears on `mtc0` to 11.
  - eff_int = `hw_int` | (`timer_pending` << 5).
  - Reset: Count=0, Compare=0, pending=0.
- **Undefined**: regs 9/11 read 0, writes are ignored, and eff_int = `hw_int`.

## Structure
- Package `cp0_pkg` holds:
  - Register numbers 9, 11, 12, 13, 14, 15.
  - SR/Cause bit positions.
  - PRID value and trap vector 0x0000_4180.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- Sub-module `cp0_timer` holds Count/Compare/pending. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- **Exception, no delay slot**: reset, then `exc_code_in`=12, vpc=0x3010, bd=0.
  - `req`=1 that cycle.
  - Next cycle: Cause=0x0000_0030, EPC=0x3010, SR.EXL=1.
- **Interrupt, delay slot**: SR=0x0000_0401, `hw_int`=6'b000001, vpc=0x3024, bd=1.
  - `req`=1, ExcCode=0, BD=1, EPC=0x3020.
  - With `exc_code_in`=4 also asserted, ExcCode stays 0.
- **Masking and eret**:
  - With EXL=1, `exc_code_in`=10 gives `req`=0.
  - `eret` clears EXL; then `exc_code_in`=10 gives `req`=1.
  - `epc_out` bypass: `mtc0` EPC=0x4000 with `eret` in the same cycle gives `epc_out`=0x4000.
- **Cancelled write**: `mtc0` SR=0xFC01 in the same cycle as `req`. SR keeps EXL=1 with the old IM/IE.
- **Reset and reads**:
  - Reset mid-trap gives all registers 0.
  - Read reg 15 gives 0x2023_0007; read reg 7 gives 0.
- **Timer (`CP0_TIMER_EN`)**:
  - Compare=20, SR=0x8001: pending sets when Count reaches 20, then `req`=1 with IP[15]=1.
  - `mtc0` to Compare clears pending.
  - Count wraps from 0xFFFF_FFFF to 0.
